// File: rtl/cam_rgb565_capture.sv
// OV7670 RGB565 capture: thresholds each pixel to RGB111 and writes it into a
// CAM_SCREEN_X x CAM_SCREEN_Y raster, flagging frame completion and framing errors.
module cam_rgb565_capture #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int AW           = 15,
    parameter int R_TH         = 16,
    parameter int G_TH         = 32,
    parameter int B_TH         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    cam_data,
    input  logic          cam_vsync,
    input  logic          cam_href,
    output logic [AW-1:0] mem_px_addr,
    output logic [2:0]    mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          frame_err
);

    localparam int CW = $clog2(CAM_SCREEN_X + 1);
    localparam int RW = $clog2(CAM_SCREEN_Y + 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(CAM_SCREEN_X);
    localparam logic [RW-1:0] ROW_MAX   = RW'(CAM_SCREEN_Y);
    localparam logic [AW-1:0] ROW_STEP  = AW'(CAM_SCREEN_X);
    localparam logic [4:0]    R_TH5     = 5'(R_TH);
    localparam logic [5:0]    G_TH6     = 6'(G_TH);
    localparam logic [4:0]    B_TH5     = 5'(B_TH);

    typedef enum logic [1:0] {S_WAIT_VS, S_VBLANK, S_LINE} state_t;

    state_t        r_state;
    logic          r_phase;
    logic [7:0]    r_hi;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [AW-1:0] r_row_base;
    logic          r_err;
    logic          r_href_d;
    logic [AW-1:0] r_px_addr;
    logic [2:0]    r_px_data;
    logic          r_px_wr;
    logic          r_frame_done;
    logic          r_frame_err;

    logic          w_phase_n;
    logic [CW-1:0] w_col_n;
    logic [RW-1:0] w_row_n;
    logic [AW-1:0] w_base_n;
    logic          w_err_n;
    logic          w_store;
    logic          w_close;
    logic [2:0]    w_rgb;
    logic          w_in_window;

    // High byte carries R[4:0],G[5:3]; the low byte on cam_data carries G[2:0],B[4:0].
    assign w_rgb = {r_hi[7:3] >= R_TH5,
                    {r_hi[2:0], cam_data[7:5]} >= G_TH6,
                    cam_data[4:0] >= B_TH5};
    assign w_in_window = (r_col < COL_MAX) && (r_row < ROW_MAX);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_phase_n = r_phase;
        w_col_n   = r_col;
        w_row_n   = r_row;
        w_base_n  = r_row_base;
        w_err_n   = r_err;
        w_store   = 1'b0;
        w_close   = 1'b0;
        if (r_state == S_LINE) begin
            if (cam_href && r_phase) begin
                if (w_in_window) w_store = 1'b1;
                else             w_err_n = 1'b1;
                if (r_col < COL_MAX) w_col_n = r_col + 1'b1;
            end
            if (cam_href) w_phase_n = ~r_phase;
            // A vsync rise closes any open line (including one ending on this very byte).
            w_close = cam_vsync ? (cam_href | r_href_d) : (r_href_d & ~cam_href);
            if (w_close) begin
                if (w_col_n != COL_MAX) w_err_n = 1'b1;
                if (w_phase_n)          w_err_n = 1'b1;
                w_phase_n = 1'b0;
                w_col_n   = '0;
                if (w_row_n < ROW_MAX) begin
                    w_row_n  = w_row_n + 1'b1;
                    w_base_n = w_base_n + ROW_STEP;
                end else begin
                    w_err_n = 1'b1;
                end
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_WAIT_VS;
            r_phase      <= 1'b0;
            r_hi         <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_row_base   <= '0;
            r_err        <= 1'b0;
            r_href_d     <= 1'b0;
            r_px_addr    <= '0;
            r_px_data    <= '0;
            r_px_wr      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_px_wr      <= w_store;
            r_frame_done <= 1'b0;
            r_href_d     <= (r_state == S_LINE) && cam_href && !cam_vsync;
            if (w_store) begin
                r_px_addr <= r_row_base + AW'(r_col);
                r_px_data <= w_rgb;
            end
            if ((r_state == S_LINE) && cam_href && !r_phase) r_hi <= cam_data;
            case (r_state)
                S_WAIT_VS: if (cam_vsync) r_state <= S_VBLANK;
                S_VBLANK: begin
                    if (!cam_vsync) begin
                        r_phase    <= 1'b0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_row_base <= '0;
                        r_err      <= 1'b0;
                        r_state    <= S_LINE;
                    end
                end
                S_LINE: begin
                    r_phase    <= w_phase_n;
                    r_col      <= w_col_n;
                    r_row      <= w_row_n;
                    r_row_base <= w_base_n;
                    r_err      <= w_err_n;
                    if (cam_vsync) begin
                        r_frame_done <= 1'b1;
                        r_frame_err  <= w_err_n | (w_row_n != ROW_MAX);
                        r_phase      <= 1'b0;
                        r_state      <= S_VBLANK;
                    end
                end
                default: r_state <= S_WAIT_VS;
            endcase
        end
    end

    assign mem_px_addr = r_px_addr;
    assign mem_px_data = r_px_data;
    assign px_wr       = r_px_wr;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Bench for cam_rgb565_capture: frames described as byte lists, expected writes
// and frame status derived from the raster rules, compared every clock.
module tb_cam_rgb565_capture;

    localparam int X  = 4;
    localparam int Y  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    cam_data = '0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [AW-1:0] mem_px_addr;
    logic [2:0]    mem_px_data;
    logic          px_wr;
    logic          frame_done;
    logic          frame_err;

    always #5 clk = ~clk;

    cam_rgb565_capture #(
        .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(AW),
        .R_TH(16), .G_TH(32), .B_TH(16)
    ) dut (
        .clk(clk), .rst(rst), .cam_data(cam_data), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
        .px_wr(px_wr), .frame_done(frame_done), .frame_err(frame_err)
    );

    typedef struct {
        int         addr;
        logic [2:0] data;
    } wr_t;

    wr_t        exp_q[$];
    bit         done_q[$];
    int         n_vec = 0;
    int         n_mis = 0;
    logic [2:0] cap_mem[16];
    bit         cap_vld[16];
    int         cap_cnt = 0;
    int         done_cnt = 0;
    bit         last_err = 1'b0;
    wr_t        mon_wr;
    bit         mon_err;

    logic [7:0] f_byte[8][24];
    int         f_len[8];
    int         f_nlines;
    bit         f_coinc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] rgb111(input logic [15:0] p);
        return {p[15:11] >= 5'd16, p[10:5] >= 6'd32, p[4:0] >= 5'd16};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_addr", 32'(mem_px_addr), 0);
            check("rst_data", 32'(mem_px_data), 0);
            check("rst_px_wr", 32'(px_wr), 0);
            check("rst_done", 32'(frame_done), 0);
            check("rst_err", 32'(frame_err), 0);
            last_err = 1'b0;
        end else begin
            if (px_wr) begin
                check("wr_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_wr = exp_q.pop_front();
                    check("wr_addr", 32'(mem_px_addr), mon_wr.addr);
                    check("wr_data", 32'(mem_px_data), 32'(mon_wr.data));
                end
                cap_mem[mem_px_addr] = mem_px_data;
                cap_vld[mem_px_addr] = 1'b1;
                cap_cnt++;
            end
            if (frame_done) begin
                check("done_expected", 32'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    mon_err = done_q.pop_front();
                    check("frame_err", 32'(frame_err), 32'(mon_err));
                    last_err = mon_err;
                end
                done_cnt++;
            end else begin
                check("frame_err_hold", 32'(frame_err), 32'(last_err));
            end
        end
    end

    task automatic clear_cap();
        for (int i = 0; i < 16; i++) begin
            cap_vld[i] = 1'b0;
            cap_mem[i] = '0;
        end
        cap_cnt = 0;
    endtask

    task automatic set_line(input int l, input int len, input logic [15:0] pix);
        f_len[l] = len;
        for (int i = 0; i < len; i++) f_byte[l][i] = (i % 2 == 1) ? pix[7:0] : pix[15:8];
    endtask

    task automatic set_px(input int l, input int p, input logic [15:0] pix);
        f_byte[l][2*p]   = pix[15:8];
        f_byte[l][2*p+1] = pix[7:0];
    endtask

    task automatic std_frame(input logic [15:0] pix);
        f_nlines = 3;
        f_coinc  = 1'b0;
        for (int l = 0; l < 8; l++) set_line(l, 8, pix);
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit vs);
        @(posedge clk); #1;
        cam_href  = 1'b1;
        cam_data  = b;
        cam_vsync = vs;
    endtask

    task automatic line_gap();
        @(posedge clk); #1;
        cam_href = 1'b0;
        cam_data = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    // Builds the expectations for the frame in f_*, then drives it and closes it with vsync.
    task automatic run_frame();
        bit  err;
        int  npx;
        int  prev_done;
        wr_t w;
        err = 1'b0;
        for (int l = 0; l < f_nlines; l++) begin
            npx = f_len[l] / 2;
            if (f_len[l] % 2 == 1) err = 1'b1;
            if (l >= Y) err = 1'b1;
            if (npx != X) err = 1'b1;
            for (int p = 0; p < npx; p++) begin
                if (p < X && l < Y) begin
                    w.addr = l * X + p;
                    w.data = rgb111({f_byte[l][2*p], f_byte[l][2*p+1]});
                    exp_q.push_back(w);
                end
            end
        end
        if (f_nlines != Y) err = 1'b1;
        done_q.push_back(err);
        prev_done = done_cnt;

        @(posedge clk); #1;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        repeat (2) @(posedge clk);
        for (int l = 0; l < f_nlines; l++) begin
            for (int i = 0; i < f_len[l]; i++)
                drive_byte(f_byte[l][i], f_coinc && (l == f_nlines - 1) && (i == f_len[l] - 1));
            if (!(f_coinc && l == f_nlines - 1)) line_gap();
        end
        @(posedge clk); #1;
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        repeat (3) @(posedge clk);
        check("writes_drained", exp_q.size(), 0);
        check("done_once", done_cnt - prev_done, 1);
    endtask

    // Five pixels land, then reset hits mid-pixel and stays quiet until the next vsync.
    task automatic run_reset_frame();
        wr_t w;
        int  prev_done;
        std_frame(16'hF800);
        for (int a = 0; a < 5; a++) begin
            w.addr = a;
            w.data = 3'b100;
            exp_q.push_back(w);
        end
        prev_done = done_cnt;
        @(posedge clk); #1;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_byte(f_byte[0][i], 1'b0);
        line_gap();
        for (int i = 0; i < 8; i++) begin
            drive_byte(f_byte[1][i], 1'b0);
            if (i == 3) rst = 1'b0;
            if (i == 5) rst = 1'b1;
        end
        line_gap();
        for (int i = 0; i < 8; i++) drive_byte(f_byte[2][i], 1'b0);
        line_gap();
        @(posedge clk); #1;
        cam_vsync = 1'b1;
        repeat (3) @(posedge clk);
        check("reset_writes", cap_cnt, 5);
        check("reset_no_done", done_cnt - prev_done, 0);
        check("reset_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        cam_vsync = 1'b1;
        repeat (3) @(posedge clk);

        std_frame(16'hF800);
        clear_cap();
        run_frame();
        check("nom_count", cap_cnt, 12);
        for (int a = 0; a < 12; a++) begin
            check("nom_vld", 32'(cap_vld[a]), 1);
            check("nom_data", 32'(cap_mem[a]), 32'b100);
        end
        check("nom_err", 32'(frame_err), 0);

        std_frame(16'hF800);
        set_px(0, 0, 16'h07E0);
        set_px(0, 1, 16'h001F);
        set_px(0, 2, 16'h0000);
        set_px(0, 3, 16'hFFFF);
        set_px(1, 0, 16'h8410);
        clear_cap();
        run_frame();
        check("th_07e0", 32'(cap_mem[0]), 32'b010);
        check("th_001f", 32'(cap_mem[1]), 32'b001);
        check("th_0000", 32'(cap_mem[2]), 32'b000);
        check("th_ffff", 32'(cap_mem[3]), 32'b111);
        check("th_8410", 32'(cap_mem[4]), 32'b111);

        std_frame(16'hF800);
        set_line(0, 10, 16'h07E0);
        clear_cap();
        run_frame();
        check("long_count", cap_cnt, 12);
        check("long_edge", 32'(cap_mem[3]), 32'b010);
        check("long_next", 32'(cap_mem[4]), 32'b100);
        check("long_err", 32'(frame_err), 1);

        std_frame(16'hF800);
        set_line(1, 6, 16'h001F);
        clear_cap();
        run_frame();
        check("short_count", cap_cnt, 11);
        check("short_skip7", 32'(cap_vld[7]), 0);
        check("short_line2", 32'(cap_vld[8]), 1);
        check("short_err", 32'(frame_err), 1);

        std_frame(16'hF800);
        set_line(0, 7, 16'h07E0);
        set_line(1, 8, 16'h001F);
        clear_cap();
        run_frame();
        check("odd_count", cap_cnt, 11);
        check("odd_skip3", 32'(cap_vld[3]), 0);
        check("odd_realign", 32'(cap_mem[4]), 32'b001);
        check("odd_err", 32'(frame_err), 1);

        std_frame(16'hF800);
        f_nlines = 4;
        set_line(3, 8, 16'h07E0);
        clear_cap();
        run_frame();
        check("extra_count", cap_cnt, 12);
        check("extra_err", 32'(frame_err), 1);

        std_frame(16'hF800);
        f_coinc = 1'b1;
        clear_cap();
        run_frame();
        check("coinc_count", cap_cnt, 12);
        check("coinc_last", 32'(cap_vld[11]), 1);
        check("coinc_err", 32'(frame_err), 0);

        clear_cap();
        run_reset_frame();
        std_frame(16'hF800);
        clear_cap();
        run_frame();
        check("post_rst_count", cap_cnt, 12);
        check("post_rst_addr0", 32'(cap_vld[0]), 1);
        check("post_rst_err", 32'(frame_err), 0);

        repeat (25) begin
            f_nlines = $urandom_range(2, 4);
            f_coinc  = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < f_nlines; l++) begin
                f_len[l] = ($urandom_range(0, 1) == 1) ? 8 : $urandom_range(1, 11);
                for (int i = 0; i < f_len[l]; i++) f_byte[l][i] = 8'($urandom);
            end
            run_frame();
        end

        repeat (5) @(posedge clk);
        check("queues_empty", exp_q.size() + done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
